receive_chars: RTL and testbench

Receive-side controller for the UART path: pops characters from the UART receiver FIFO and stores them in the character RAM at consecutive addresses starting from a fixed base. It stops after a programmed number of characters or after storing a terminator character, whichever comes first. It sits between the UART receiver's FIFO read port and the shared character RAM, mirroring the transmit-side controller that reads that RAM out to the UART transmitter.

---
 rtl/receive_chars_pkg.sv | 27 ++
 rtl/receive_chars.sv | 134 +++++++++++++
 tb/tb_receive_chars.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/receive_chars_pkg.sv
// Constants shared by the UART receive and transmit controllers: RAM geometry,
// character format, transfer framing and the common 2-bit state encoding.
`default_nettype none

package receive_chars_pkg;

  localparam int RAM_ADDR_BITS = 6;
  localparam int DATA_BITS     = 8;

  localparam logic [RAM_ADDR_BITS-1:0] START_ADDRESS = 6'd0;
  localparam logic [DATA_BITS-1:0]     TERMINATOR    = 8'h0D;

  localparam int STATE_BITS = 2;
  typedef logic [STATE_BITS-1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_WAIT_CHAR = 2'd1;
  localparam state_t ST_WRITE     = 2'd2;
  localparam state_t ST_FINISH    = 2'd3;

  function automatic logic is_terminator(input logic [DATA_BITS-1:0] ch);
    return ch == TERMINATOR;
  endfunction

endpackage

`default_nettype wire

// File: rtl/receive_chars.sv
// Pops characters from the UART receive FIFO and writes them to the character
// RAM from START_ADDRESS on, stopping at a character limit or after a terminator.
`default_nettype none

module receive_chars
  import receive_chars_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] max_chars,
  input  logic                     rx_empty,
  input  logic [DATA_BITS-1:0]     rx_data,
  output logic                     read_uart,
  output logic [RAM_ADDR_BITS-1:0] ram_address,
  output logic [DATA_BITS-1:0]     ram_data,
  output logic                     write_or_read,
  output logic                     receiving,
  output logic                     done,
  output logic [RAM_ADDR_BITS-1:0] char_count
);

  state_t                     state;
  state_t                     state_next;
  logic [RAM_ADDR_BITS-1:0]   limit;
  logic [RAM_ADDR_BITS-1:0]   limit_next;
  logic                       read_uart_next;
  logic [RAM_ADDR_BITS-1:0]   ram_address_next;
  logic [DATA_BITS-1:0]       ram_data_next;
  logic                       write_or_read_next;
  logic                       receiving_next;
  logic                       done_next;
  logic [RAM_ADDR_BITS-1:0]   char_count_next;
  logic                       limit_reached;

  assign limit_reached = (char_count == limit);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The limit check outranks a waiting character so a zero limit pops nothing.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_WAIT_CHAR;
      end
      ST_WAIT_CHAR: begin
        if (limit_reached)  state_next = ST_FINISH;
        else if (!rx_empty) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (is_terminator(ram_data)) state_next = ST_FINISH;
        else                         state_next = ST_WAIT_CHAR;
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs; strobes default low, the rest hold.
  always_comb begin
    limit_next         = limit;
    read_uart_next     = 1'b0;
    write_or_read_next = 1'b0;
    done_next          = 1'b0;
    ram_address_next   = ram_address;
    ram_data_next      = ram_data;
    receiving_next     = receiving;
    char_count_next    = char_count;
    case (state)
      ST_IDLE: begin
        if (start) begin
          limit_next       = max_chars;
          ram_address_next = START_ADDRESS;
          char_count_next  = '0;
          receiving_next   = 1'b1;
        end
      end
      ST_WAIT_CHAR: begin
        if (!limit_reached && !rx_empty) begin
          ram_data_next      = rx_data;
          read_uart_next     = 1'b1;
          write_or_read_next = 1'b1;
        end
      end
      ST_WRITE: begin
        ram_address_next = ram_address + 1'b1;
        char_count_next  = char_count + 1'b1;
      end
      ST_FINISH: begin
        receiving_next = 1'b0;
        done_next      = 1'b1;
      end
      default: begin
        receiving_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      limit         <= '0;
      read_uart     <= 1'b0;
      write_or_read <= 1'b0;
      receiving     <= 1'b0;
      done          <= 1'b0;
      ram_address   <= START_ADDRESS;
      ram_data      <= '0;
      char_count    <= '0;
    end else begin
      limit         <= limit_next;
      read_uart     <= read_uart_next;
      write_or_read <= write_or_read_next;
      receiving     <= receiving_next;
      done          <= done_next;
      ram_address   <= ram_address_next;
      ram_data      <= ram_data_next;
      char_count    <= char_count_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_receive_chars.sv
// Bench for receive_chars: per-cycle vector table with a directly driven FIFO
// port, then a FIFO/RAM model for full transfers, slow sources, wrap and abort.
`default_nettype none

module tb_receive_chars;

  logic       clock;
  logic       reset;
  logic       start;
  logic [5:0] max_chars;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       read_uart;
  logic [5:0] ram_address;
  logic [7:0] ram_data;
  logic       write_or_read;
  logic       receiving;
  logic       done;
  logic [5:0] char_count;

  receive_chars dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .max_chars     (max_chars),
    .rx_empty      (rx_empty),
    .rx_data       (rx_data),
    .read_uart     (read_uart),
    .ram_address   (ram_address),
    .ram_data      (ram_data),
    .write_or_read (write_or_read),
    .receiving     (receiving),
    .done          (done),
    .char_count    (char_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       st;
    logic [5:0] mx;
    logic       emp;
    logic [7:0] dat;
    logic       e_rd;
    logic       e_wr;
    logic [5:0] e_a;
    logic [7:0] e_d;
    logic       e_rcv;
    logic       e_dn;
    logic [5:0] e_cnt;
  } vec_t;

  vec_t       vecs[$];
  int         vectors = 0;
  int         miscompares = 0;

  logic [7:0] fifo[$];
  logic [7:0] ram[64];
  bit         model_on = 0;
  int         pulses = 0;
  int         writes = 0;
  int         dones = 0;
  logic       prev_rd = 1'b0;

  task automatic add(input logic rst, st, input logic [5:0] mx, input logic emp,
                     input logic [7:0] dat, input logic e_rd, e_wr,
                     input logic [5:0] e_a, input logic [7:0] e_d,
                     input logic e_rcv, e_dn, input logic [5:0] e_cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.mx = mx; v.emp = emp; v.dat = dat;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_a = e_a; v.e_d = e_d;
    v.e_rcv = e_rcv; v.e_dn = e_dn; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    if (model_on) begin
      rx_empty = (fifo.size() == 0);
      rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end
  endtask

  task automatic push(input logic [7:0] c);
    fifo.push_back(c);
    refresh();
  endtask

  // Advance one clock; FIFO pops and RAM writes use the outputs of the cycle just ended.
  task automatic tick();
    logic       pre_rd, pre_wr, pre_dn;
    logic [5:0] pre_a;
    logic [7:0] pre_d;
    pre_rd = read_uart; pre_wr = write_or_read; pre_dn = done;
    pre_a  = ram_address; pre_d = ram_data;
    @(posedge clock);
    #1;
    if (model_on) begin
      if (pre_rd === 1'b1) begin
        pulses++;
        if (prev_rd === 1'b1) begin
          miscompares++;
          $display("FAIL back_to_back_pop: got read_uart=1 on two cycles, expected one");
        end
        if (fifo.size() == 0) begin
          miscompares++;
          $display("FAIL pop_underflow: got pop of empty fifo, expected none");
        end else begin
          void'(fifo.pop_front());
        end
      end
      if (pre_wr === 1'b1) begin
        writes++;
        ram[pre_a] = pre_d;
      end
      if (pre_dn === 1'b1) dones++;
      prev_rd = pre_rd;
      refresh();
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = dones;
    n  = 0;
    while (dones == d0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, (dones != d0), 1);
  endtask

  task automatic run_xfer(input string name, input logic [5:0] mx, input int budget);
    start = 1'b1;
    max_chars = mx;
    tick();
    start = 1'b0;
    wait_done(name, budget);
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 64; i++) ram[i] = 8'hFF;
  endtask

  initial begin
    int         p0, w0, d0, errs, n;
    logic       bad;
    logic [5:0] mx;

    reset = 1'b0; start = 1'b0; max_chars = '0; rx_empty = 1'b1; rx_data = '0;

    //  rst st mx emp dat     rd wr addr data  rcv dn cnt
    add(0, 1, 3, 0, 8'h41,    0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 3, 0, 8'h41,    0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 3, 0, 8'h41,    0, 0, 0, 8'h00, 0, 0, 0);
    add(1, 1, 2, 1, 8'h00,    0, 0, 0, 8'h00, 1, 0, 0);
    add(1, 0, 0, 1, 8'h00,    0, 0, 0, 8'h00, 1, 0, 0);
    add(1, 0, 0, 0, 8'h41,    1, 1, 0, 8'h41, 1, 0, 0);
    add(1, 0, 0, 1, 8'h00,    0, 0, 1, 8'h41, 1, 0, 1);
    add(1, 0, 0, 0, 8'h0D,    1, 1, 1, 8'h0D, 1, 0, 1);
    add(1, 0, 0, 0, 8'h42,    0, 0, 2, 8'h0D, 1, 0, 2);
    add(1, 0, 0, 0, 8'h42,    0, 0, 2, 8'h0D, 0, 1, 2);
    add(1, 0, 0, 0, 8'h42,    0, 0, 2, 8'h0D, 0, 0, 2);
    add(1, 1, 0, 0, 8'h55,    0, 0, 0, 8'h0D, 1, 0, 0);
    add(1, 0, 0, 0, 8'h55,    0, 0, 0, 8'h0D, 1, 0, 0);
    add(1, 0, 0, 0, 8'h55,    0, 0, 0, 8'h0D, 0, 1, 0);
    add(1, 0, 0, 0, 8'h55,    0, 0, 0, 8'h0D, 0, 0, 0);
    add(1, 1, 1, 0, 8'h31,    0, 0, 0, 8'h0D, 1, 0, 0);
    add(1, 1, 1, 0, 8'h31,    1, 1, 0, 8'h31, 1, 0, 0);
    add(1, 1, 1, 1, 8'h00,    0, 0, 1, 8'h31, 1, 0, 1);
    add(1, 1, 1, 1, 8'h00,    0, 0, 1, 8'h31, 1, 0, 1);
    add(1, 1, 1, 1, 8'h00,    0, 0, 1, 8'h31, 0, 1, 1);
    add(1, 1, 2, 1, 8'h00,    0, 0, 0, 8'h31, 1, 0, 0);
    add(0, 1, 2, 0, 8'h77,    0, 0, 0, 8'h00, 0, 0, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; start = vecs[i].st; max_chars = vecs[i].mx;
      rx_empty = vecs[i].emp; rx_data = vecs[i].dat;
      tick();
      check($sformatf("vec%0d", i),
            {8'h00, read_uart, write_or_read, ram_address, ram_data, receiving, done, char_count},
            {8'h00, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_a, vecs[i].e_d,
             vecs[i].e_rcv, vecs[i].e_dn, vecs[i].e_cnt});
    end

    model_on = 1;
    start = 1'b0;
    refresh();
    tick(); tick();
    reset = 1'b1;
    tick();

    // Count-limited transfer leaves the fifth character behind.
    clear_ram();
    p0 = pulses; d0 = dones;
    push("A"); push("B"); push("C"); push("D"); push("E");
    run_xfer("count", 6'd4, 100);
    tick(); tick();
    check("count_ram", {ram[0], ram[1], ram[2], ram[3]}, "ABCD");
    check("count_pops", pulses - p0, 4);
    check("count_char_count", char_count, 4);
    check("count_address", ram_address, 4);
    check("count_done_pulses", dones - d0, 1);
    check("count_left", {fifo.size() == 1, (fifo.size() != 0) ? fifo[0] : 8'h00}, {1'b1, 8'h45});
    fifo.delete(); refresh();

    // Terminator is stored and ends the transfer early.
    clear_ram();
    d0 = dones;
    push("H"); push("I"); push(8'h0D); push("X");
    run_xfer("term", 6'd10, 100);
    tick();
    check("term_ram", {ram[0], ram[1], ram[2]}, {8'h48, 8'h49, 8'h0D});
    check("term_char_count", char_count, 3);
    check("term_done_pulses", dones - d0, 1);
    check("term_left", {fifo.size() == 1, (fifo.size() != 0) ? fifo[0] : 8'h00}, {1'b1, 8'h58});
    fifo.delete(); refresh();

    // Slow source: nothing moves while the FIFO is empty.
    clear_ram();
    push("S");
    start = 1'b1; max_chars = 6'd2; tick(); start = 1'b0;
    tick(); tick(); tick();
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      bad = bad | read_uart | write_or_read;
    end
    check("slow_idle_quiet", {bad, receiving, char_count}, {1'b0, 1'b1, 6'd1});
    push("T");
    wait_done("slow", 50);
    check("slow_ram", {ram[0], ram[1]}, "ST");

    // Zero limit ends with nothing popped.
    p0 = pulses;
    push("Z");
    run_xfer("zero", 6'd0, 20);
    check("zero_pops", {pulses - p0, 26'd0, char_count}, 0);
    check("zero_left", fifo.size(), 1);
    fifo.delete(); refresh();

    // Largest limit fills addresses 0..62.
    clear_ram();
    w0 = writes;
    for (int i = 0; i < 63; i++) push(8'h20 + 8'(i));
    run_xfer("wrap", 6'd63, 400);
    errs = 0;
    for (int i = 0; i < 63; i++) if (ram[i] !== 8'h20 + 8'(i)) errs++;
    check("wrap_ram_errors", errs, 0);
    check("wrap_writes", writes - w0, 63);
    check("wrap_address", {ram_address, char_count}, {6'd63, 6'd63});
    fifo.delete(); refresh();

    // Abort after two characters, then a fresh transfer starts at address 0.
    clear_ram();
    w0 = writes;
    push("a"); push("b"); push("c"); push("d"); push("e");
    start = 1'b1; max_chars = 6'd5; tick(); start = 1'b0;
    n = 0;
    while (writes - w0 < 2 && n < 50) begin
      tick();
      n++;
    end
    check("abort_two_written", writes - w0, 2);
    reset = 1'b0;
    tick();
    check("abort_reset_outputs",
          {read_uart, write_or_read, ram_address, ram_data, receiving, done, char_count},
          24'd0);
    reset = 1'b1;
    w0 = writes;
    for (int i = 0; i < 5; i++) tick();
    check("abort_no_writes", {writes - w0, fifo.size()}, {32'd0, 32'd3});
    mx = 6'd3;
    run_xfer("rerun", mx, 100);
    check("rerun_ram", {ram[0], ram[1], ram[2]}, "cde");
    check("rerun_address", ram_address, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
